// File: rtl/ahb_pkg.sv
// Shared AHB transfer/burst encodings and beat-counter sizing for the bus arbiter.
package ahb_pkg;

  localparam int HTRANS_W = 2;
  localparam int HBURST_W = 3;
  localparam int BEAT_W   = 2;

  typedef enum logic [HTRANS_W-1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [HBURST_W-1:0] HBURST_SINGLE = 3'b000;
  localparam logic [HBURST_W-1:0] HBURST_INCR4  = 3'b011;

  // Beats still to come after the NONSEQ of an INCR4 burst.
  localparam logic [BEAT_W-1:0] INCR4_BEATS_LEFT = 2'd3;

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// Request/grant and transfer-qualifier signals between the AHB masters and the arbiter.
interface ahb_bus_arbiter_if
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int MW          = $clog2(NUM_MASTERS)
);
  logic [NUM_MASTERS-1:0] hbusreq;
  logic [NUM_MASTERS-1:0] hlock;
  logic [HTRANS_W-1:0]    htrans;
  logic [HBURST_W-1:0]    hburst;
  logic                   hready;
  logic [NUM_MASTERS-1:0] hgrant;
  logic [MW-1:0]          hmaster;
  logic                   hmastlock;

  modport slave (
    input  hbusreq, hlock, htrans, hburst, hready,
    output hgrant, hmaster, hmastlock
  );

  modport master (
    output hbusreq, hlock, htrans, hburst, hready,
    input  hgrant, hmaster, hmastlock
  );
endinterface

// File: rtl/ahb_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: scans last+1, last+2, ... and returns the first requester.
module rr_pick #(
  parameter int NUM_MASTERS = 3,
  parameter int MW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [MW-1:0]          last,
  output logic [NUM_MASTERS-1:0] gnt_onehot,
  output logic [MW-1:0]          gnt_idx,
  output logic                   any
);

  logic [MW-1:0] w_cand;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    w_cand     = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      w_cand = MW'((int'(last) + k) % NUM_MASTERS);
      if (!any && req[w_cand]) begin
        any                = 1'b1;
        gnt_idx            = w_cand;
        gnt_onehot[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter in front of the AHB2APB bridge: holds INCR4 bursts and locked
// sequences on one master, parks on DEFAULT_MASTER, and tracks the address-phase owner.
module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 3,
  parameter int MW             = $clog2(NUM_MASTERS),
  parameter int DEFAULT_MASTER = 0
) (
  input  logic              hclk,
  input  logic              hreset,
  ahb_bus_arbiter_if.slave  bus
);

  localparam logic [NUM_MASTERS-1:0] DEFAULT_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [MW-1:0]          DEFAULT_IDX = MW'(DEFAULT_MASTER);

  logic [BEAT_W-1:0]      r_beat_cnt;
  logic [BEAT_W-1:0]      w_beat_cnt_nxt;
  logic [NUM_MASTERS-1:0] r_hgrant;
  logic [NUM_MASTERS-1:0] w_hgrant_nxt;
  logic [MW-1:0]          r_gnt_idx;
  logic [MW-1:0]          w_gnt_idx_nxt;
  logic [MW-1:0]          r_rr_last;
  logic [MW-1:0]          w_rr_last_nxt;
  logic [MW-1:0]          r_hmaster;
  logic                   r_hmastlock;
  logic                   w_arb_en;
  logic [NUM_MASTERS-1:0] w_pick_onehot;
  logic [MW-1:0]          w_pick_idx;
  logic                   w_pick_any;

  rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .MW          (MW)
  ) u_rr_pick (
    .req        (bus.hbusreq),
    .last       (r_rr_last),
    .gnt_onehot (w_pick_onehot),
    .gnt_idx    (w_pick_idx),
    .any        (w_pick_any)
  );

  // Remaining-beat count of the current owner's burst; non-INCR4 bursts behave as SINGLE.
  always_comb begin
    w_beat_cnt_nxt = r_beat_cnt;
    case (bus.htrans)
      HTRANS_NONSEQ: w_beat_cnt_nxt = (bus.hburst == HBURST_INCR4) ? INCR4_BEATS_LEFT : '0;
      HTRANS_SEQ:    if (r_beat_cnt != '0) w_beat_cnt_nxt = r_beat_cnt - 1'b1;
      HTRANS_IDLE:   w_beat_cnt_nxt = '0;
      default:       w_beat_cnt_nxt = r_beat_cnt;
    endcase
  end

  assign w_arb_en = bus.hready && (w_beat_cnt_nxt == '0) && !bus.hlock[r_hmaster];

  always_comb begin
    w_hgrant_nxt  = r_hgrant;
    w_gnt_idx_nxt = r_gnt_idx;
    w_rr_last_nxt = r_rr_last;
    if (w_arb_en) begin
      if (w_pick_any) begin
        w_hgrant_nxt  = w_pick_onehot;
        w_gnt_idx_nxt = w_pick_idx;
        w_rr_last_nxt = w_pick_idx;
      end else begin
        w_hgrant_nxt  = DEFAULT_GNT;
        w_gnt_idx_nxt = DEFAULT_IDX;
      end
    end
  end

  // Ownership of the address phase follows the grant one hready-qualified edge later.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_beat_cnt  <= '0;
      r_hgrant    <= DEFAULT_GNT;
      r_gnt_idx   <= DEFAULT_IDX;
      r_rr_last   <= DEFAULT_IDX;
      r_hmaster   <= DEFAULT_IDX;
      r_hmastlock <= 1'b0;
    end else if (bus.hready) begin
      r_beat_cnt  <= w_beat_cnt_nxt;
      r_hgrant    <= w_hgrant_nxt;
      r_gnt_idx   <= w_gnt_idx_nxt;
      r_rr_last   <= w_rr_last_nxt;
      r_hmaster   <= r_gnt_idx;
      r_hmastlock <= bus.hlock[r_gnt_idx];
    end
  end

  assign bus.hgrant    = r_hgrant;
  assign bus.hmaster   = r_hmaster;
  assign bus.hmastlock = r_hmastlock;

endmodule
